// File: rtl/div_16by8_seq.sv
// -----------------------------------------------------------------------------
// div_16by8_seq
//
// Sequential non-restoring divider: divides a 2*WIDTH-bit unsigned dividend by
// a WIDTH-bit unsigned divisor. It produces one quotient bit per cycle, then
// spends one cycle correcting the remainder. The interface is a start/busy/ready
// handshake.
//
// Optional feature macro: DIV_OVF_CHECK_EN
//   Defined   : quotient overflow (z[2W-1:W] >= b, including b == 0) is
//               detected when start is accepted. The iterations are skipped and
//               the result is q = all ones, r = 0, ovf = 1, with ready one cycle
//               after acceptance.
//   Undefined : ovf is tied to 0. Every division takes WIDTH+1 cycles. q/r for
//               overflowing inputs are whatever the algorithm produces.
//
// Ports:
//   clk   in   1        clock, rising edge
//   clrn  in   1        asynchronous active-low clear
//   start in   1        request, accepted on a rising edge while busy = 0
//   z     in   2*WIDTH  dividend, captured on acceptance
//   b     in   WIDTH    divisor, captured on acceptance
//   q     out  WIDTH    quotient, valid from ready until the next accepted start
//   r     out  WIDTH    remainder, same validity as q
//   busy  out  1        division in progress
//   ready out  1        one-cycle pulse: q/r/ovf are valid
//   ovf   out  1        overflow / divide-by-zero, valid with ready
//
// Timing: start accepted at edge N -> ITER for edges N+1..N+WIDTH -> FIX loads
// the results at edge N+WIDTH+1. Ready is high (and busy low) in the cycle
// after that edge, so a new start can be issued in the ready cycle itself.
// -----------------------------------------------------------------------------
module div_16by8_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 clrn,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   z,
   input  logic [WIDTH-1:0]     b,
   output logic [WIDTH-1:0]     q,
   output logic [WIDTH-1:0]     r,
   output logic                 busy,
   output logic                 ready,
   output logic                 ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [WIDTH-1:0]        q_q, q_d;
   logic [WIDTH-1:0]        r_q, r_d;
   logic                    ready_q, ready_d;

   // Datapath working registers (not reset: always loaded on acceptance)
   logic [WIDTH-1:0]        zlo_q, zlo_d;   // low dividend bits still to shift in
   logic [WIDTH-1:0]        b_q, b_d;
   logic signed [WIDTH:0]   rem_q, rem_d;   // signed partial remainder
   logic [WIDTH-1:0]        quo_q, quo_d;

   logic signed [WIDTH:0]   b_ext;
   logic signed [WIDTH:0]   shifted;
   logic signed [WIDTH:0]   step;

`ifdef DIV_OVF_CHECK_EN
   logic                    ovf_q, ovf_d;
   logic                    ovfp_q, ovfp_d; // overflow flagged at acceptance
`endif

   // Final non-restoring correction: a negative remainder needs b added back.
   function automatic logic [WIDTH-1:0] fix_rem(input logic signed [WIDTH:0] rem,
                                                input logic [WIDTH-1:0]      bv);
      logic signed [WIDTH:0] t;
      t = rem;
      if (rem[WIDTH]) begin
         t = rem + $signed({1'b0, bv});
      end
      return t[WIDTH-1:0];
   endfunction

   // One non-restoring step: shift in the next dividend bit, then subtract b
   // when the remainder is non-negative and add b when it is negative. Wrap
   // around in the W+1-bit intermediate is harmless because the true result
   // always lies in [-b, b).
   always_comb begin
      b_ext   = $signed({1'b0, b_q});
      shifted = $signed({rem_q[WIDTH-1:0], zlo_q[WIDTH-1]});
      step    = rem_q[WIDTH] ? (shifted + b_ext) : (shifted - b_ext);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      ready_d = 1'b0;
      zlo_d   = zlo_q;
      b_d     = b_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
`ifdef DIV_OVF_CHECK_EN
      ovf_d   = ovf_q;
      ovfp_d  = ovfp_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               zlo_d   = z[WIDTH-1:0];
               b_d     = b;
               rem_d   = $signed({1'b0, z[2*WIDTH-1:WIDTH]});
               quo_d   = '0;
               cnt_d   = '0;
               state_d = S_ITER;
`ifdef DIV_OVF_CHECK_EN
               ovfp_d  = 1'b0;
               // The quotient fits in WIDTH bits only if the upper dividend
               // half is below b. Preloading all-ones / zero lets FIX
               // publish the saturated result unchanged.
               if (z[2*WIDTH-1:WIDTH] >= b) begin
                  ovfp_d  = 1'b1;
                  quo_d   = '1;
                  rem_d   = '0;
                  state_d = S_FIX;
               end
`endif
            end
         end

         S_ITER: begin
            rem_d = step;
            zlo_d = zlo_q << 1;
            quo_d = {quo_q[WIDTH-2:0], ~step[WIDTH]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            q_d     = quo_q;
            r_d     = fix_rem(rem_q, b_q);
            ready_d = 1'b1;
            state_d = S_IDLE;
`ifdef DIV_OVF_CHECK_EN
            ovf_d   = ovfp_q;
`endif
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         ready_q <= 1'b0;
`ifdef DIV_OVF_CHECK_EN
         ovf_q   <= 1'b0;
         ovfp_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         ready_q <= ready_d;
`ifdef DIV_OVF_CHECK_EN
         ovf_q   <= ovf_d;
         ovfp_q  <= ovfp_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      zlo_q <= zlo_d;
      b_q   <= b_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
   end

   assign q     = q_q;
   assign r     = r_q;
   assign busy  = (state_q != S_IDLE);
   assign ready = ready_q;
`ifdef DIV_OVF_CHECK_EN
   assign ovf   = ovf_q;
`else
   assign ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_div_16by8_seq.sv
// -----------------------------------------------------------------------------
// Testbench for div_16by8_seq (WIDTH = 8). Expected results come from plain
// integer division; the latency is 9 cycles, or 1 for an overflow when
// DIV_OVF_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_div_16by8_seq;

   logic        clk;
   logic        clrn;
   logic        start;
   logic [15:0] z;
   logic [7:0]  b;
   logic [7:0]  q;
   logic [7:0]  r;
   logic        busy;
   logic        ready;
   logic        ovf;

   int n_checks = 0;
   int n_fail   = 0;

   div_16by8_seq #(.WIDTH(8)) dut (
      .clk   (clk),
      .clrn  (clrn),
      .start (start),
      .z     (z),
      .b     (b),
      .q     (q),
      .r     (r),
      .busy  (busy),
      .ready (ready),
      .ovf   (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: plain unsigned division.
   // chk = 0 means q/r are unspecified for these operands.
   function automatic void model(input logic [15:0] zv, input logic [7:0] bv,
                                 output logic [7:0] qe, output logic [7:0] re,
                                 output logic oe, output int le, output logic chk);
      int unsigned zi;
      int unsigned bi;
      zi = zv;
      bi = bv;
      if (bi == 0 || (zi / bi) > 255) begin
`ifdef DIV_OVF_CHECK_EN
         qe = 8'hFF; re = 8'h00; oe = 1'b1; le = 1; chk = 1'b1;
`else
         qe = 8'h00; re = 8'h00; oe = 1'b0; le = 9; chk = 1'b0;
`endif
      end else begin
         qe = 8'(zi / bi); re = 8'(zi % bi); oe = 1'b0; le = 9; chk = 1'b1;
      end
   endfunction

   // Issue one start (called just after a rising edge) and observe until ready.
   // lat = -1 if ready never came. poke_at >= 0 re-pulses start with other
   // operands that many cycles after acceptance.
   task automatic run_div(input logic [15:0] zv, input logic [7:0] bv, input int poke_at,
                          output int lat, output int busy_n, output logic busy_rdy,
                          output logic [7:0] qo, output logic [7:0] ro, output logic ov);
      lat = -1; busy_n = 0; busy_rdy = 1'b1; qo = 8'h00; ro = 8'h00; ov = 1'b0;
      start = 1'b1; z = zv; b = bv;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         if (ready === 1'b1) begin
            lat = k; qo = q; ro = r; ov = ovf; busy_rdy = busy;
            break;
         end
         if (busy === 1'b1) busy_n++;
         start = (k == poke_at);
         if (k == poke_at) begin
            z = ~zv;
            b = bv ^ 8'h5A;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      clrn = 1'b0; start = 1'b0; z = 16'h0; b = 8'h0;
      #3;
      n_checks++;
      if ({q, r, busy, ready, ovf} !== 19'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got q=%h r=%h busy=%b ready=%b ovf=%b, want all zero", q, r, busy, ready, ovf);
      end
      @(posedge clk); @(posedge clk); #2;
      n_checks++;
      if ({busy, ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_held: got busy=%b ready=%b, want 0 0", busy, ready);
      end
      clrn = 1'b1;
   endtask

   task automatic check_op(input string name, input logic [15:0] zv, input logic [7:0] bv,
                           input int lat, input int busy_n, input logic busy_rdy,
                           input logic [7:0] qo, input logic [7:0] ro, input logic ov);
      logic [7:0] qe, re;
      logic oe, chk;
      int le;
      model(zv, bv, qe, re, oe, le, chk);
      n_checks++;
      if (lat !== le) begin
         n_fail++;
         $display("FAIL %s_latency z=%h b=%h: got %0d, want %0d", name, zv, bv, lat, le);
      end
      n_checks++;
      if (busy_n !== le || busy_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_busy z=%h b=%h: got %0d busy cycles (busy at ready=%b), want %0d and 0", name, zv, bv, busy_n, busy_rdy, le);
      end
      n_checks++;
      if (ov !== oe) begin
         n_fail++;
         $display("FAIL %s_ovf z=%h b=%h: got %b, want %b", name, zv, bv, ov, oe);
      end
      if (chk) begin
         n_checks++;
         if (qo !== qe || ro !== re) begin
            n_fail++;
            $display("FAIL %s_result z=%h b=%h: got q=%h r=%h, want q=%h r=%h", name, zv, bv, qo, ro, qe, re);
         end
      end
   endtask

   task automatic test_basic();
      int lat, bn; logic br, ov; logic [7:0] qo, ro;
      @(posedge clk); #1;
      run_div(16'hFE01, 8'hFF, -1, lat, bn, br, qo, ro, ov);
      check_op("basic", 16'hFE01, 8'hFF, lat, bn, br, qo, ro, ov);
      @(posedge clk); #1;
      n_checks++;
      if (ready !== 1'b0 || q !== 8'hFF || r !== 8'h00) begin
         n_fail++;
         $display("FAIL ready_pulse_hold: got ready=%b q=%h r=%h, want 0 ff 00", ready, q, r);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] zs [3] = '{16'h0000, 16'h0007, 16'h03FC};
      logic [7:0]  bs [3] = '{8'h01, 8'h02, 8'h04};
      int lat, bn; logic br, ov; logic [7:0] qo, ro;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         run_div(zs[i], bs[i], -1, lat, bn, br, qo, ro, ov);
         check_op("b2b", zs[i], bs[i], lat, bn, br, qo, ro, ov);
      end
   endtask

   task automatic test_ignore_start();
      int lat, bn; logic br, ov; logic [7:0] qo, ro;
      @(posedge clk); #1;
      run_div(16'h1234, 8'h56, 3, lat, bn, br, qo, ro, ov);
      check_op("ignore_start", 16'h1234, 8'h56, lat, bn, br, qo, ro, ov);
   endtask

   task automatic test_overflow();
      int lat, bn; logic br, ov; logic [7:0] qo, ro;
      @(posedge clk); #1;
      run_div(16'h0400, 8'h04, -1, lat, bn, br, qo, ro, ov);
      check_op("ovf_a", 16'h0400, 8'h04, lat, bn, br, qo, ro, ov);
`ifdef DIV_OVF_CHECK_EN
      run_div(16'h1234, 8'h00, -1, lat, bn, br, qo, ro, ov);
      check_op("ovf_div0", 16'h1234, 8'h00, lat, bn, br, qo, ro, ov);
`endif
   endtask

   task automatic test_random();
      int lat, bn; logic br, ov; logic [7:0] qo, ro;
      logic [15:0] zv; logic [7:0] bv;
      @(posedge clk); #1;
      for (int i = 0; i < 40; i++) begin
         bv = 8'($urandom_range(1, 255));
         zv = {8'($urandom_range(0, int'(bv) - 1)), 8'($urandom)};
`ifdef DIV_OVF_CHECK_EN
         if ($urandom_range(0, 4) == 0) begin
            bv = 8'($urandom_range(0, 255));
            zv = {8'($urandom_range(int'(bv), 255)), 8'($urandom)};
         end
`endif
         run_div(zv, bv, -1, lat, bn, br, qo, ro, ov);
         check_op("random", zv, bv, lat, bn, br, qo, ro, ov);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat, bn, rdy_seen; logic br, ov; logic [7:0] qo, ro;
      @(posedge clk); #1;
      run_div(16'hFE01, 8'hFF, -1, lat, bn, br, qo, ro, ov);
      start = 1'b1; z = 16'hFE01; b = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      clrn = 1'b0;
      #1;
      n_checks++;
      if ({q, r, busy, ready} !== 18'h0) begin
         n_fail++;
         $display("FAIL reset_mid_async: got q=%h r=%h busy=%b ready=%b, want all zero", q, r, busy, ready);
      end
      @(posedge clk); #1;
      clrn = 1'b1;
      rdy_seen = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         if (ready === 1'b1 || busy === 1'b1) rdy_seen++;
      end
      n_checks++;
      if (rdy_seen !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: got %0d cycles with ready/busy after release, want 0", rdy_seen);
      end
      run_div(16'hFE01, 8'hFF, -1, lat, bn, br, qo, ro, ov);
      check_op("after_reset", 16'hFE01, 8'hFF, lat, bn, br, qo, ro, ov);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignore_start();
      test_overflow();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, limit 200000 ns");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/div_16by8_seq.md
Name: div_16by8_seq

Overview:
- Sequential non-restoring divider; the inverse of the 8x8 Wallace product path.
- Takes a 2*WIDTH-bit dividend (typically a product z) and a WIDTH-bit divisor.
- Returns a WIDTH-bit quotient and a WIDTH-bit remainder via a start/busy/ready handshake.
- Used to recover an operand from a product and in the datapath's DIV unit.

Parameters:
WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH bits.

Ports:
clk  input  1  clock, rising edge.
clrn  input  1  asynchronous active-low reset (clear).
start  input  1  request; sampled on a rising clk edge only while busy=0.
z  input  2*WIDTH  dividend; captured when start is accepted.
b  input  WIDTH  divisor; captured when start is accepted.
q  output  WIDTH  quotient; valid from the ready pulse until the next accepted start.
r  output  WIDTH  remainder; same validity as q.
busy  output  1  high while a division is in progress.
ready  output  1  one-cycle pulse marking q/r (and ovf) valid.
ovf  output  1  quotient overflow or divide-by-zero; valid with ready (see Optional Feature).

Behaviour:
- Reset: clrn low forces q=0, r=0, busy=0, ready=0, ovf=0, iteration count=0, state=IDLE, immediately and asynchronously.
- Reset mid-operation: the division is abandoned. After clrn rises, the block sits in IDLE and waits for a new start.
- States:
  - IDLE: busy=0. start=1 at an edge captures z and b, sets busy=1 and enters ITER. q/r hold their previous values until ready.
  - ITER: WIDTH cycles, one quotient bit per cycle (non-restoring).
    - Partial remainder is WIDTH+1 bits, signed.
    - If partial remainder >= 0: shift left, bring in the next dividend bit, subtract b.
    - Otherwise: shift left, bring in the next dividend bit, add b.
    - Quotient bit = NOT sign of the new partial remainder.
    - Count runs 0..WIDTH-1. After the WIDTH-1 iteration, go to FIX.
  - FIX: one cycle.
    - If the final partial remainder is negative, add b (remainder correction).
    - Load q and r, clear busy, pulse ready=1 for exactly this one cycle, return to IDLE.
- Latency: start accepted at edge N, then ready=1 during cycle N+WIDTH+1 (9 cycles for WIDTH=8).
- Back-to-back: start may be asserted in the ready cycle; it is accepted, since busy=0 in that cycle.
- Start while busy=1 is ignored. z/b changes while busy do not affect the running operation.
- Width rules: all arithmetic is unsigned on the operands. Internal remainder is WIDTH+1 bits. Quotient is truncated to WIDTH bits.
- Overflow: z[2*WIDTH-1:WIDTH] >= b, which includes b=0, means the true quotient does not fit in WIDTH bits.

Optional Feature:
- Macro: DIV_OVF_CHECK_EN.
- Defined:
  - At start acceptance, overflow is checked combinationally on z/b.
  - If overflow: skip ITER, go directly to FIX with q={WIDTH{1'b1}}, r=0, ovf=1, ready pulsed at edge N+1 (latency 1).
  - Otherwise ovf=0 and normal latency applies.
- Not defined:
  - No check; ovf is tied to 0.
  - Every division takes WIDTH+1 cycles.
  - q/r for overflow or b=0 inputs are the raw algorithm output, undefined for checking purposes.

Test Plan:
- z=16'hFE01, b=8'hFF, start for 1 cycle -> ready after 9 cycles; q=8'hFF, r=8'h00, ovf=0; busy high for exactly those cycles.
- z=16'h0000, b=8'h01 -> q=8'h00, r=8'h00. Then z=16'h0007, b=8'h02 -> q=8'h03, r=8'h01. Then z=16'h03FC, b=8'h04 -> q=8'hFF, r=8'h00. Each start is issued in the previous ready cycle; no idle gap is allowed.
- Start pulsed again 3 cycles into a division with different z/b -> ignored; original result delivered at the original ready cycle.
- With DIV_OVF_CHECK_EN: z=16'h0400, b=8'h04 -> ready at N+1, ovf=1, q=8'hFF, r=8'h00. z=16'h1234, b=8'h00 -> same response.
- Without DIV_OVF_CHECK_EN: z=16'h0400, b=8'h04 -> ready at N+9, ovf=0.
- clrn pulsed low at iteration 4 of z=16'hFE01 / b=8'hFF -> busy, ready, q and r go to 0 immediately, with no ready pulse afterward. A fresh start after release -> correct result q=8'hFF, r=8'h00.
